// File: rtl/square_racer_pkg.sv
// Shared constants and types for the square racer game.
// Screen geometry, lane layout and scheduler state encoding.
package square_racer_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int LANE_X0       = 120;
  localparam int LANE_PITCH    = 140;
  localparam int N_LANES       = 4;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    MOVE,
    CHECK,
    HIT
  } state_t;

  function automatic logic [9:0] lane_x(
    input int base,
    input int step,
    input int lane
  );
    return 10'(base + lane * step);
  endfunction

endpackage

// File: rtl/bar_scheduler_if.sv
// Game-side signal bundle of the bar scheduler.
// master drives game inputs, slave is the scheduler.
interface bar_scheduler_if;

  logic       ienable;
  logic       irestart;
  logic       iframe_tick;
  logic [9:0] iplayer_x;
  logic [9:0] iplayer_y;
  logic [9:0] ipixel_x;
  logic [9:0] ipixel_y;
  logic       obar_on;
  logic [9:0] obar_rgb;
  logic       ocollision;
  logic [7:0] oscore;
  logic       obusy;

  modport master (
    output ienable, irestart, iframe_tick,
    output iplayer_x, iplayer_y,
    output ipixel_x, ipixel_y,
    input  obar_on, obar_rgb,
    input  ocollision, oscore, obusy
  );

  modport slave (
    input  ienable, irestart, iframe_tick,
    input  iplayer_x, iplayer_y,
    input  ipixel_x, ipixel_y,
    output obar_on, obar_rgb,
    output ocollision, oscore, obusy
  );

endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4, shifting left.
// Steps only on request so lane choice is reproducible.
module lfsr8
  import square_racer_pkg::*;
(
  input  logic       iclk,
  input  logic       irst_n,
  input  logic       iload,
  input  logic       istep,
  output logic [7:0] oval
);

  logic fb;

  assign fb = oval[7] ^ oval[5] ^ oval[4] ^ oval[3];

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      oval <= LFSR_SEED;
    end else if (iload) begin
      oval <= LFSR_SEED;
    end else if (istep) begin
      oval <= {oval[6:0], fb};
    end
  end

endmodule

// File: rtl/bar_scheduler.sv
// Falling bar sequencer: per-frame move, respawn, collision
// and score, plus the combinational bar pixel source.
module bar_scheduler
  import square_racer_pkg::*;
#(
  parameter int         N_BARS    = 3,
  parameter int         BAR_W     = 40,
  parameter int         BAR_H     = 50,
  parameter int         PLAYER_S  = 20,
  parameter int         SCREEN_H  = SCREEN_HEIGHT,
  parameter int         SPEED     = 2,
  parameter int         SPACING   = 160,
  parameter int         LANE_BASE = LANE_X0,
  parameter int         LANE_STEP = LANE_PITCH,
  parameter logic [9:0] BAR_COLOR = 10'b0
) (
  input logic             iclk,
  input logic             irst_n,
  bar_scheduler_if.slave  bus
);

  localparam logic [1:0] LAST = 2'(N_BARS - 1);

  state_t     state, state_nx;
  logic [1:0] idx;
  logic [7:0] score;
  logic       coll;
  logic [7:0] lfsr;
  logic       lfsr_unused;
  logic [9:0] bar_x [N_BARS];
  logic [9:0] bar_y [N_BARS];
  logic [9:0] cur_x, cur_y;
  logic [9:0] new_x;
  logic       wrap, hit, on;

  lfsr8 u_lfsr (
    .iclk   (iclk),
    .irst_n (irst_n),
    .iload  (bus.irestart),
    .istep  (state == CHECK && wrap),
    .oval   (lfsr)
  );

  assign lfsr_unused = ^lfsr[7:2];
  assign new_x = lane_x(LANE_BASE, LANE_STEP, int'(lfsr[1:0]));

  always_comb begin
    cur_x = '0;
    cur_y = '0;
    for (int i = 0; i < N_BARS; i++) begin
      if (idx == 2'(i)) begin
        cur_x = bar_x[i];
        cur_y = bar_y[i];
      end
    end
  end

  // Widened to 11 bits so edge sums cannot overflow.
  assign wrap = cur_y >= 10'(SCREEN_H);
  assign hit  = state == CHECK && !wrap
             && {1'b0, bus.iplayer_x} < {1'b0, cur_x} + 11'(BAR_W)
             && {1'b0, cur_x} < {1'b0, bus.iplayer_x} + 11'(PLAYER_S)
             && {1'b0, bus.iplayer_y} < {1'b0, cur_y} + 11'(BAR_H)
             && {1'b0, cur_y} < {1'b0, bus.iplayer_y} + 11'(PLAYER_S);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.ienable) state_nx = WAIT;
      WAIT: begin
        if (!bus.ienable)         state_nx = IDLE;
        else if (bus.iframe_tick) state_nx = MOVE;
      end
      MOVE:  state_nx = CHECK;
      CHECK: begin
        if (hit)              state_nx = HIT;
        else if (idx == LAST) state_nx = WAIT;
      end
      HIT:   state_nx = HIT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state <= IDLE;
      idx   <= '0;
      score <= '0;
      coll  <= 1'b0;
      for (int i = 0; i < N_BARS; i++) begin
        bar_x[i] <= lane_x(LANE_BASE, LANE_STEP, i);
        bar_y[i] <= 10'(i * SPACING);
      end
    end else if (bus.irestart) begin
      state <= IDLE;
      idx   <= '0;
      score <= '0;
      coll  <= 1'b0;
      for (int i = 0; i < N_BARS; i++) begin
        bar_x[i] <= lane_x(LANE_BASE, LANE_STEP, i);
        bar_y[i] <= 10'(i * SPACING);
      end
    end else begin
      state <= state_nx;
      if (state == MOVE) begin
        idx <= '0;
        for (int i = 0; i < N_BARS; i++) begin
          bar_y[i] <= bar_y[i] + 10'(SPEED);
        end
      end
      if (state == CHECK) begin
        if (!hit) idx <= idx + 2'd1;
        if (hit)  coll <= 1'b1;
        if (wrap) begin
          if (score != 8'hFF) score <= score + 8'd1;
          for (int i = 0; i < N_BARS; i++) begin
            if (idx == 2'(i)) begin
              bar_y[i] <= '0;
              bar_x[i] <= new_x;
            end
          end
        end
      end
    end
  end

  always_comb begin
    on = 1'b0;
    for (int i = 0; i < N_BARS; i++) begin
      if ({1'b0, bar_x[i]} < {1'b0, bus.ipixel_x}
       && {1'b0, bus.ipixel_x} < {1'b0, bar_x[i]} + 11'(BAR_W)
       && {1'b0, bar_y[i]} < {1'b0, bus.ipixel_y}
       && {1'b0, bus.ipixel_y} < {1'b0, bar_y[i]} + 11'(BAR_H))
        on = 1'b1;
    end
  end

  assign bus.obar_on    = on;
  assign bus.obar_rgb   = on ? BAR_COLOR : 10'b0;
  assign bus.ocollision = coll;
  assign bus.oscore     = score;
  assign bus.obusy      = state == MOVE || state == CHECK;

endmodule

// File: tb/tb_bar_scheduler.sv
// Directed bench for bar_scheduler: pixel table, frame
// timing, wrap/lane, collision, enable and score saturation.
module tb_bar_scheduler;
  import square_racer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   busy;

  always #5 clk = ~clk;

  bar_scheduler_if bus ();
  bar_scheduler_if sbus ();

  bar_scheduler dut (
    .iclk   (clk),
    .irst_n (rst_n),
    .bus    (bus)
  );

  bar_scheduler #(.SPEED(480)) sat (
    .iclk   (clk),
    .irst_n (rst_n),
    .bus    (sbus)
  );

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic       on;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic probe(input logic [9:0] px,
                       input logic [9:0] py,
                       input logic exp,
                       input string name);
    @(negedge clk);
    bus.ipixel_x = px;
    bus.ipixel_y = py;
    #1;
    check(name, 32'(bus.obar_on), 32'(exp));
  endtask

  task automatic frame(output int busy_cycles);
    bus.iframe_tick = 1'b1;
    @(negedge clk);
    bus.iframe_tick = 1'b0;
    busy_cycles = 0;
    for (int j = 0; j < 6; j++) begin
      if (bus.obusy) busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic sframe();
    sbus.iframe_tick = 1'b1;
    @(negedge clk);
    sbus.iframe_tick = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic restart();
    @(negedge clk);
    bus.irestart = 1'b1;
    @(negedge clk);
    bus.irestart = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{10'd130, 10'd10,  1'b1};
    vecs[1]  = '{10'd120, 10'd10,  1'b0};
    vecs[2]  = '{10'd160, 10'd10,  1'b0};
    vecs[3]  = '{10'd159, 10'd10,  1'b1};
    vecs[4]  = '{10'd130, 10'd0,   1'b0};
    vecs[5]  = '{10'd130, 10'd49,  1'b1};
    vecs[6]  = '{10'd130, 10'd50,  1'b0};
    vecs[7]  = '{10'd270, 10'd200, 1'b1};
    vecs[8]  = '{10'd410, 10'd330, 1'b1};
    vecs[9]  = '{10'd410, 10'd369, 1'b1};
    vecs[10] = '{10'd300, 10'd100, 1'b0};
    vecs[11] = '{10'd439, 10'd321, 1'b1};
    vecs[12] = '{10'd440, 10'd321, 1'b0};

    bus.ienable = 0; bus.irestart = 0; bus.iframe_tick = 0;
    bus.iplayer_x = 0; bus.iplayer_y = 10'd400;
    bus.ipixel_x = 0; bus.ipixel_y = 0;
    sbus.ienable = 0; sbus.irestart = 0; sbus.iframe_tick = 0;
    sbus.iplayer_x = 0; sbus.iplayer_y = 0;
    sbus.ipixel_x = 0; sbus.ipixel_y = 0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_coll", 32'(bus.ocollision), 0);
    check("rst_score", 32'(bus.oscore), 0);
    check("rst_busy", 32'(bus.obusy), 0);
    check("rst_state", 32'(dut.state), 32'(IDLE));

    for (int i = 0; i < 13; i++) begin
      probe(vecs[i].px, vecs[i].py, vecs[i].on, $sformatf("pix%0d", i));
      check($sformatf("rgb%0d", i), 32'(bus.obar_rgb), 0);
    end

    // First frame: every bar moves down by 2.
    bus.ienable = 1'b1;
    repeat (2) @(negedge clk);
    frame(busy);
    check("busy_len", 32'(busy), 4);
    check("score_f1", 32'(bus.oscore), 0);
    probe(10'd130, 10'd2,   1'b0, "b0_y2_edge");
    probe(10'd130, 10'd3,   1'b1, "b0_y2_in");
    probe(10'd270, 10'd162, 1'b0, "b1_y162_edge");
    probe(10'd270, 10'd163, 1'b1, "b1_y162_in");
    probe(10'd410, 10'd323, 1'b1, "b2_y322_in");

    repeat (78) frame(busy);
    check("score_f79", 32'(bus.oscore), 0);
    probe(10'd410, 10'd479, 1'b1, "b2_y478");

    // Frame 80: bar 2 reaches 480 and respawns in lane 1.
    frame(busy);
    check("score_f80", 32'(bus.oscore), 1);
    check("coll_f80", 32'(bus.ocollision), 0);
    probe(10'd270, 10'd1,   1'b1, "b2_wrap_lane1");
    probe(10'd410, 10'd479, 1'b0, "b2_gone");
    probe(10'd130, 10'd160, 1'b0, "b0_y160_edge");
    probe(10'd130, 10'd161, 1'b1, "b0_y160_in");
    probe(10'd270, 10'd321, 1'b1, "b1_y320_in");

    // Collision with bar 2 on the first frame after restart.
    bus.iplayer_x = 10'd405;
    bus.iplayer_y = 10'd330;
    restart();
    check("rs_score", 32'(bus.oscore), 0);
    check("rs_coll", 32'(bus.ocollision), 0);
    repeat (2) @(negedge clk);
    bus.iframe_tick = 1'b1;
    @(negedge clk);
    bus.iframe_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("coll_k4", 32'(bus.ocollision), 0);
    @(negedge clk);
    check("coll_k5", 32'(bus.ocollision), 1);
    check("hit_state", 32'(dut.state), 32'(HIT));
    check("hit_busy", 32'(bus.obusy), 0);
    repeat (3) frame(busy);
    check("hit_sticky", 32'(bus.ocollision), 1);
    check("hit_score", 32'(bus.oscore), 0);
    probe(10'd410, 10'd322, 1'b0, "hit_b2_edge");
    probe(10'd410, 10'd323, 1'b1, "hit_b2_frozen");
    probe(10'd130, 10'd3,   1'b1, "hit_b0_frozen");

    bus.ienable = 1'b0;
    restart();
    check("clr_coll", 32'(bus.ocollision), 0);
    probe(10'd410, 10'd320, 1'b0, "clr_b2_edge");
    probe(10'd410, 10'd321, 1'b1, "clr_b2_home");
    probe(10'd130, 10'd1,   1'b1, "clr_b0_home");

    // Disabled: ticks are ignored.
    repeat (3) frame(busy);
    check("dis_busy", 32'(busy), 0);
    check("dis_state", 32'(dut.state), 32'(IDLE));
    probe(10'd130, 10'd1,   1'b1, "dis_b0_still");
    probe(10'd410, 10'd321, 1'b1, "dis_b2_still");

    // Enable dropped mid-sweep: the sweep completes, then IDLE.
    bus.iplayer_x = 0;
    bus.iplayer_y = 10'd400;
    bus.ienable = 1'b1;
    repeat (2) @(negedge clk);
    bus.iframe_tick = 1'b1;
    @(negedge clk);
    bus.iframe_tick = 1'b0;
    @(negedge clk);
    bus.ienable = 1'b0;
    @(negedge clk);
    check("drop_busy_k3", 32'(bus.obusy), 1);
    repeat (2) @(negedge clk);
    check("drop_wait_k5", 32'(dut.state), 32'(WAIT));
    @(negedge clk);
    check("drop_idle_k6", 32'(dut.state), 32'(IDLE));
    probe(10'd130, 10'd2, 1'b0, "drop_b0_edge");
    probe(10'd130, 10'd3, 1'b1, "drop_b0_moved");

    // Fast instance: all three bars wrap each frame.
    sbus.ienable = 1'b1;
    repeat (2) @(negedge clk);
    sframe();
    check("sat_f1", 32'(sbus.oscore), 3);
    repeat (83) sframe();
    check("sat_f84", 32'(sbus.oscore), 252);
    sframe();
    check("sat_f85", 32'(sbus.oscore), 255);
    repeat (5) sframe();
    check("sat_hold", 32'(sbus.oscore), 255);
    check("sat_coll", 32'(sbus.ocollision), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
